// File: rtl/avalon_pio_bank_pkg.sv
// Shared constants and helpers for the Avalon PIO bank: register offsets,
// edge-mode encoding and an elaboration-time clog2.
package avalon_pio_pkg;

    localparam logic [2:0] REG_DATA_OUT = 3'd0;
    localparam logic [2:0] REG_SET      = 3'd1;
    localparam logic [2:0] REG_CLR      = 3'd2;
    localparam logic [2:0] REG_TGL      = 3'd3;
    localparam logic [2:0] REG_DATA_IN  = 3'd4;
    localparam logic [2:0] REG_EDGE_CAP = 3'd5;
    localparam logic [2:0] REG_IRQ_MASK = 3'd6;
    localparam logic [2:0] REG_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    function automatic int pio_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/avalon_pio_bank_if.sv
// Avalon-MM slave bus for the PIO bank: {channel, reg[2:0]} word address,
// active-low strobes, 32-bit data.
interface avalon_pio_bank_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, read_n, writedata,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, read_n, writedata,
                    output readdata);
endinterface

// File: rtl/avalon_pio_bank_in_channel.sv
// One input channel: synchroniser, prev flop, edge detect and sticky
// EDGE_CAP with write-1-to-clear.
module pio_in_channel
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             armed,
    input  logic [WIDTH-1:0] in_bits,
    input  logic [WIDTH-1:0] w1c,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] edge_cap
);
    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0]                  prev;
    logic [WIDTH-1:0]                  edge_det;

    assign data_in = sync[SYNC_STAGES-1];

    always_comb begin
        edge_det = '0;
        case (MODE)
            EDGE_RISE: edge_det = data_in & ~prev;
            EDGE_FALL: edge_det = ~data_in & prev;
            default:   edge_det = data_in ^ prev;
        endcase
        // Sync/prev start at zero, so suppress edges until the pipe has filled.
        if (!armed) edge_det = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            prev     <= '0;
            edge_cap <= '0;
        end else begin
            sync[0] <= in_bits;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            prev     <= data_in;
            // A new edge wins over a same-cycle clear.
            edge_cap <= (edge_cap & ~w1c) | edge_det;
        end
    end
endmodule

// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO bank: NUM_CH output registers with set/clear/toggle,
// synchronised inputs with edge capture and a maskable registered irq.
module avalon_pio_bank
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               NUM_CH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = 0,
    parameter int               ADDR_W      = pio_clog2(NUM_CH) + 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_pio_bank_if.slave        bus,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    input  logic [NUM_CH*WIDTH-1:0] in_port,
    output logic                    irq
);
    logic [NUM_CH-1:0][WIDTH-1:0] dout_q, mask_q, din, cap, w1c;
    logic [31:0]      ch_sel;
    logic [2:0]       offset;
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [2:0]       prime_cnt;
    logic             armed;
    logic [31:0]      rdata;
    logic             unused_ok;

    assign ch_sel    = 32'(bus.address >> 3);
    assign offset    = bus.address[2:0];
    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign armed     = (prime_cnt == 3'(SYNC_STAGES + 1));
    assign out_port  = dout_q;
    assign unused_ok = ^{bus.read_n, bus.writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) dout_q[c] <= RESET_VAL;
            mask_q    <= '0;
            prime_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            if (!armed) prime_cnt <= prime_cnt + 3'd1;
            irq <= |(cap & mask_q);
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr && ch_sel == c) begin
                    case (offset)
                        REG_DATA_OUT: dout_q[c] <= wd;
                        REG_SET:      dout_q[c] <= dout_q[c] | wd;
                        REG_CLR:      dout_q[c] <= dout_q[c] & ~wd;
                        REG_TGL:      dout_q[c] <= dout_q[c] ^ wd;
                        REG_IRQ_MASK: mask_q[c] <= wd;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w1c = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (wr && ch_sel == c && offset == REG_EDGE_CAP) w1c[c] = wd;
    end

    // Out-of-range channels match no iteration and read back as zero.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == c) begin
                case (offset)
                    REG_DATA_OUT: rdata[WIDTH-1:0] = dout_q[c];
                    REG_DATA_IN:  rdata[WIDTH-1:0] = din[c];
                    REG_EDGE_CAP: rdata[WIDTH-1:0] = cap[c];
                    REG_IRQ_MASK: rdata[WIDTH-1:0] = mask_q[c];
                    default: ;
                endcase
            end
        end
    end
    assign bus.readdata = rdata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pio_in_channel #(
            .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)
        ) u_in (
            .clk     (clk),
            .reset_n (reset_n),
            .armed   (armed),
            .in_bits (in_port[c*WIDTH +: WIDTH]),
            .w1c     (w1c[c]),
            .data_in (din[c]),
            .edge_cap(cap[c])
        );
    end
endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed bench for avalon_pio_bank: expectations are queued as stimulus is
// driven and popped against DUT outputs after the relevant clock edges.
module tb_avalon_pio_bank;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int AW    = 6;   // wide enough to address channel 5

    logic clk = 1'b0;
    logic reset_n;
    logic [NCH*WIDTH-1:0] out_port, in_port;
    logic irq;

    avalon_pio_bank_if #(.ADDR_W(AW)) bus ();

    avalon_pio_bank #(
        .WIDTH(WIDTH), .NUM_CH(NCH), .RESET_VAL(8'hA5),
        .SYNC_STAGES(2), .EDGE_MODE(0), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .out_port(out_port), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input int ch, input logic [2:0] off, input logic [7:0] d);
        bus.address    = {3'(ch), off};
        bus.writedata  = {24'hFFFFFF, d};   // upper bits must be ignored
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input int ch, input logic [2:0] off,
                      input logic [31:0] exp);
        bus.address    = {3'(ch), off};
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        sb_push(tag, exp);
        #1;
        sb_cmp(bus.readdata);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_cmp(obs);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = '1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = '0;
        idle(2);
        reset_n = 1'b1;

        // Reset state, inputs held high through release
        chk("rst_out", out_port, 32'hA5A5A5A5);
        chk("rst_irq", 32'(irq), 32'd0);
        idle(6);
        for (int c = 0; c < NCH; c++) rd("rst_cap", c, 3'd5, 32'h0);
        rd("rst_din", 3, 3'd4, 32'hFF);
        chk("rst_irq_late", 32'(irq), 32'd0);

        // Falling edges are not captured in rising mode
        in_port = '0;
        idle(5);
        rd("fall_cap", 2, 3'd5, 32'h0);

        // Ch1 atomic ops
        wr(1, 3'd0, 8'h0F); chk("dout_wr", out_port, 32'hA5A50FA5); rd("rb_0F", 1, 3'd0, 32'h0F);
        wr(1, 3'd1, 8'hF0); chk("dout_set", out_port, 32'hA5A5FFA5); rd("rb_FF", 1, 3'd0, 32'hFF);
        wr(1, 3'd2, 8'h03); chk("dout_clr", out_port, 32'hA5A5FCA5); rd("rb_FC", 1, 3'd0, 32'hFC);
        wr(1, 3'd3, 8'h81); chk("dout_tgl", out_port, 32'hA5A57DA5); rd("rb_7D", 1, 3'd0, 32'h7D);
        rd("rd_set", 1, 3'd1, 32'h0);
        rd("rd_tgl", 1, 3'd3, 32'h0);

        // Ch2 bit3 rising edge: DATA_IN after 2 cycles, EDGE_CAP after 3
        in_port[19] = 1'b1;
        idle(2);
        rd("din_2cyc", 2, 3'd4, 32'h08);
        rd("cap_early", 2, 3'd5, 32'h0);
        idle(1);
        rd("cap_3cyc", 2, 3'd5, 32'h08);
        rd("cap_other", 1, 3'd5, 32'h0);
        in_port[19] = 1'b0;
        idle(4);
        rd("cap_after_fall", 2, 3'd5, 32'h08);
        chk("irq_unmasked", 32'(irq), 32'd0);
        wr(2, 3'd5, 8'h08);
        rd("cap_w1c", 2, 3'd5, 32'h0);

        // Masked interrupt
        wr(2, 3'd6, 8'h08);
        rd("mask_rb", 2, 3'd6, 32'h08);
        in_port[19] = 1'b1;
        idle(3);
        rd("cap_irq", 2, 3'd5, 32'h08);
        chk("irq_not_yet", 32'(irq), 32'd0);
        idle(1);
        chk("irq_high", 32'(irq), 32'd1);
        wr(2, 3'd5, 8'h08);
        rd("cap_clr2", 2, 3'd5, 32'h0);
        idle(1);
        chk("irq_drop_w1c", 32'(irq), 32'd0);

        // Edge and W1C on the same cycle: edge wins
        in_port[19] = 1'b0;
        idle(4);
        in_port[19] = 1'b1;
        idle(4);
        chk("irq_again", 32'(irq), 32'd1);
        in_port[19] = 1'b0;
        idle(4);
        in_port[19] = 1'b1;
        idle(2);
        wr(2, 3'd5, 8'h08);            // lands on the capture edge
        rd("cap_edge_wins", 2, 3'd5, 32'h08);
        chk("irq_stays", 32'(irq), 32'd1);
        idle(1);
        chk("irq_stays2", 32'(irq), 32'd1);

        // Mask clear drops irq with capture still set
        wr(2, 3'd6, 8'h00);
        idle(1);
        chk("irq_mask_off", 32'(irq), 32'd0);
        rd("cap_kept", 2, 3'd5, 32'h08);

        // Out-of-range channel and reserved offset
        rd("ch5_dout", 5, 3'd0, 32'h0);
        rd("ch5_cap", 5, 3'd5, 32'h0);
        rd("rsvd_rd", 1, 3'd7, 32'h0);
        wr(5, 3'd0, 8'hFF);
        wr(5, 3'd6, 8'hFF);
        wr(1, 3'd7, 8'hFF);
        wr(2, 3'd4, 8'h00);
        chk("oor_out", out_port, 32'hA5A57DA5);
        rd("oor_mask", 1, 3'd6, 32'h0);
        rd("oor_cap", 2, 3'd5, 32'h08);
        chk("oor_irq", 32'(irq), 32'd0);

        // Back-to-back writes
        wr(0, 3'd0, 8'h11);
        wr(0, 3'd1, 8'h22);
        wr(0, 3'd3, 8'h01);
        chk("b2b_out", out_port, 32'hA5A57D32);

        // Mid-run reset with irq asserted and input still high
        wr(2, 3'd6, 8'h08);
        idle(1);
        chk("irq_pre_rst", 32'(irq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out", out_port, 32'hA5A5A5A5);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        idle(1);
        reset_n = 1'b1;
        rd("mid_rst_cap", 2, 3'd5, 32'h0);
        rd("mid_rst_mask", 2, 3'd6, 32'h0);
        idle(6);
        rd("reprime_cap", 2, 3'd5, 32'h0);
        rd("reprime_din", 2, 3'd4, 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
